// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: arbiter state,
// write-back queue entry and the "write discarded" register address.
package regfile_wr_arbiter_pkg;

  // Entry field widths; the register file has 32 registers (see pend_mask).
  localparam int unsigned ENTRY_AW = 5;
  localparam int unsigned ENTRY_DW = 32;

  // Writes to register 0 are accepted but never reach the register file.
  localparam logic [ENTRY_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_B = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                live;
    logic [ENTRY_AW-1:0] addr;
    logic [ENTRY_DW-1:0] data;
  } wb_entry_t;

  // One-hot register select used to build the pending-register mask.
  function automatic logic [31:0] reg_onehot(input logic [ENTRY_AW-1:0] addr);
    return 32'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Write-back bus between the two sources (master) and the arbiter (slave),
// including the register-file write outputs and hazard/status signals.
// Optional REGFILE_ARB_STATS_EN adds the conflict_cnt statistics output.
interface regfile_wr_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          rf_wr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [31:0]   pend_mask;
  logic          starve;
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0]   conflict_cnt;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_wr, rf_addr, rf_data, pend_mask, starve,
           conflict_cnt
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_wr, rf_addr, rf_data, pend_mask, starve,
           conflict_cnt
  );
`else
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_wr, rf_addr, rf_data, pend_mask, starve
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_wr, rf_addr, rf_data, pend_mask, starve
  );
`endif
endinterface

// File: rtl/regfile_wb_queue.sv
// DEPTH-entry FIFO of multicycle write-backs. Each entry carries a live bit
// so younger pipeline writes can kill queued writes to the same register;
// dead entries stay in order and are dropped when they reach the head.
module regfile_wb_queue
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  wb_entry_t           push_entry,
  input  logic                pop,
  input  logic                squash,
  input  logic [ENTRY_AW-1:0] squash_addr,
  output logic                full,
  output logic                empty,
  output wb_entry_t           head,
  output logic [31:0]         pend_mask
);
  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t       mem [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [PW-1:0]   wr_idx;
  logic [PW-1:0]   rd_idx;
  logic            push_ok;
  logic            pop_ok;
  wb_entry_t       push_fill;

  assign wr_idx  = wr_ptr[PW-1:0];
  assign rd_idx  = rd_ptr[PW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_idx];

  // Incoming entry is killed if a same-cycle squash targets its register.
  always_comb begin
    push_fill      = push_entry;
    push_fill.live = push_entry.live && !(squash && (push_entry.addr == squash_addr));
  end

  // Slots outside the occupied window always hold live=0, so the mask can
  // simply OR over every slot.
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem[i].live) pend_mask = pend_mask | reg_onehot(mem[i].addr);
    end
  end

  // Storage, pointers, squash and live-bit maintenance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (squash && mem[i].live && (mem[i].addr == squash_addr)) mem[i].live <= 1'b0;
      end
      if (pop_ok) begin
        mem[rd_idx].live <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        mem[wr_idx] <= push_fill;
        wr_ptr      <= wr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// write-back (A, priority) and the queued multicycle write-back (B), with a
// starvation guard that forces one B issue after MAX_WAIT lost cycles.
// Optional REGFILE_ARB_STATS_EN adds a saturating A-over-B conflict counter.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned AW       = ENTRY_AW,
  parameter int unsigned DW       = ENTRY_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [CW-1:0] wait_q;
  logic [CW-1:0] wait_d;
  logic [CW-1:0] wait_inc;
  logic          a_win;
  logic          b_issue;
  logic          pop;
  logic          q_full;
  logic          q_empty;
  wb_entry_t     q_head;
  wb_entry_t     push_entry;
  logic          head_live;
  logic          head_dead;
  logic          a_nonzero;
  logic          rf_wr_q;
  logic [AW-1:0] rf_addr_q;
  logic [DW-1:0] rf_data_q;

  assign head_live  = !q_empty && q_head.live;
  assign head_dead  = !q_empty && !q_head.live;
  assign a_nonzero  = (bus.a_addr != AW'(REG_ZERO));
  assign wait_inc   = wait_q + 1'b1;
  assign push_entry = '{live: (bus.b_addr != AW'(REG_ZERO)), addr: bus.b_addr, data: bus.b_data};

  regfile_wb_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (bus.b_valid),
    .push_entry (push_entry),
    .pop        (pop),
    .squash     (a_win && a_nonzero),
    .squash_addr(bus.a_addr),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head),
    .pend_mask  (bus.pend_mask)
  );

  // Grant selection, queue pop and starvation tracking. A dead head is
  // dropped in the same cycle whatever else is granted.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    a_win   = 1'b0;
    b_issue = 1'b0;
    pop     = 1'b0;
    case (state_q)
      NORMAL: begin
        a_win   = bus.a_valid;
        b_issue = !bus.a_valid && head_live;
        pop     = b_issue || head_dead;
        if (q_empty || b_issue) begin
          wait_d = '0;
        end else if (a_win && head_live) begin
          wait_d = wait_inc;
          if (wait_inc >= CW'(MAX_WAIT)) state_d = FORCE_B;
        end
      end
      FORCE_B: begin
        b_issue = head_live;
        pop     = !q_empty;
        wait_d  = '0;
        state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  // State, wait counter and registered register-file write outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= NORMAL;
      wait_q    <= '0;
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (a_win) begin
        rf_wr_q <= a_nonzero;
        if (a_nonzero) begin
          rf_addr_q <= bus.a_addr;
          rf_data_q <= bus.a_data;
        end
      end else if (b_issue) begin
        rf_wr_q   <= 1'b1;
        rf_addr_q <= q_head.addr;
        rf_data_q <= q_head.data;
      end else begin
        rf_wr_q <= 1'b0;
      end
    end
  end

  assign bus.a_ready = reset && a_win;
  assign bus.b_ready = !q_full;
  assign bus.rf_wr   = rf_wr_q;
  assign bus.rf_addr = rf_addr_q;
  assign bus.rf_data = rf_data_q;
  assign bus.starve  = (state_q == FORCE_B);

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] conflict_q;

  // Saturating count of cycles where A took the port from a live B head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= '0;
    end else if (a_win && head_live && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 1'b1;
    end
  end

  assign bus.conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_regfile_wr_arbiter;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  regfile_wr_arbiter_if #(.AW(AW), .DW(DW)) bus();

  regfile_wr_arbiter #(
    .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending B writes as an ordered list with live flags.
  typedef struct {
    bit          live;
    int          addr;
    logic [31:0] data;
  } item_t;

  item_t       mq[$];
  bit          m_force;
  int          m_wait;
  bit          m_wr;
  int          m_addr;
  logic [31:0] m_data;
  int          m_conf;

  // Observations from the DUT write port.
  int          wr_seen = 0;
  int          starve_seen = 0;
  int          b7_hit = 0;
  logic [31:0] shadow [32];
  bit          last_a_ready = 1'b0;
  bit          last_b_ready = 1'b1;

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_force = 1'b0;
    m_wait  = 0;
    m_wr    = 1'b0;
    m_addr  = 0;
    m_data  = '0;
    m_conf  = 0;
  endtask

  // One clock: drive inputs just after the falling edge, compare, advance
  // the model, and return at the next falling edge.
  task automatic step(input bit av, input int aa, input logic [31:0] ad,
                      input bit bv, input int ba, input logic [31:0] bd);
    bit live_head;
    bit a_win;
    bit b_room;
    bit b_issue;
    bus.a_valid = av;
    bus.a_addr  = AW'(aa);
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = AW'(ba);
    bus.b_data  = bd;
    #1;
    live_head = (mq.size() > 0) && mq[0].live;
    a_win     = av && !m_force;
    b_room    = mq.size() < DEPTH;
    check("a_ready", bus.a_ready, a_win);
    check("b_ready", bus.b_ready, b_room);
    check("rf_wr", bus.rf_wr, m_wr);
    check("rf_addr", bus.rf_addr, m_addr);
    check("rf_data", bus.rf_data, m_data);
    check("pend_mask", bus.pend_mask, model_mask());
    check("starve", bus.starve, m_force);
`ifdef REGFILE_ARB_STATS_EN
    check("conflict_cnt", bus.conflict_cnt, m_conf);
`endif
    if (bus.rf_wr === 1'b1) begin
      wr_seen++;
      shadow[bus.rf_addr] = bus.rf_data;
      if (bus.rf_addr == 5'd7 && bus.rf_data == 32'hB0B0_0007) b7_hit++;
    end
    if (bus.starve === 1'b1) starve_seen++;
    last_a_ready = bus.a_ready;
    last_b_ready = bus.b_ready;

    // Next registered write.
    b_issue = !a_win && live_head;
    if (a_win) begin
      m_wr = (aa != 0);
      if (aa != 0) begin m_addr = aa; m_data = ad; end
    end else if (b_issue) begin
      m_wr = 1'b1; m_addr = mq[0].addr; m_data = mq[0].data;
    end else begin
      m_wr = 1'b0;
    end
    if (a_win && live_head && m_conf < 65535) m_conf++;
    // Starvation guard.
    if (m_force) begin
      m_force = 1'b0; m_wait = 0;
    end else if (mq.size() == 0 || b_issue) begin
      m_wait = 0;
    end else if (a_win && live_head) begin
      m_wait++;
      if (m_wait >= MAX_WAIT) m_force = 1'b1;
    end
    // Queue update: drop issued/dead head, squash, then push.
    if (mq.size() > 0 && (b_issue || !mq[0].live)) void'(mq.pop_front());
    if (a_win && aa != 0) foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
    if (bv && b_room)
      mq.push_back('{live: (ba != 0) && !(a_win && aa != 0 && ba == aa), addr: ba, data: bd});

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int s0;
    bit          cav, cbv;
    int          caa, cba;
    logic [31:0] cad, cbd;
    int          pa;

    foreach (shadow[i]) shadow[i] = '0;
    model_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0;   bus.b_data = '0;
    #3;
    check("rst_a_ready", bus.a_ready, 1'b0);
    check("rst_rf_wr", bus.rf_wr, 1'b0);
    check("rst_rf_addr", bus.rf_addr, 0);
    check("rst_rf_data", bus.rf_data, 0);
    check("rst_pend", bus.pend_mask, 0);
    check("rst_starve", bus.starve, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // A only.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("a_only_ready", last_a_ready, 1'b1);
    #1;
    check("a_only_wr", bus.rf_wr, 1'b1);
    check("a_only_addr", bus.rf_addr, 5);
    check("a_only_data", bus.rf_data, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);

    // Fill the queue while A is busy.
    for (int i = 0; i < 4; i++) step(1, 20 + i, 32'h100 + i, 1, 8 + i, 32'hB00 + i);
    #1;
    check("fill_b_ready", bus.b_ready, 1'b0);
    check("fill_pend", bus.pend_mask, 32'h0000_0F00);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

    // Starvation: one queued B, A requesting continuously.
    s0 = starve_seen;
    step(1, 21, 32'h21, 1, 12, 32'hC);
    for (int i = 0; i < 12; i++) step(1, 21, 32'h21, 0, 0, 0);
    check("starve_once", starve_seen - s0, 1);
    check("starve_b_written", shadow[12], 32'hC);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // WAW squash.
    step(1, 3, 32'h3, 1, 7, 32'hB0B0_0007);
    step(1, 7, 32'h1, 0, 0, 0);
    #1;
    check("waw_pend7", bus.pend_mask[7], 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    check("waw_no_b7", b7_hit, 0);
    check("waw_final7", shadow[7], 32'h1);

    // Register 0 from both sources.
    base = wr_seen;
    step(1, 0, 32'h55, 1, 0, 32'h66);
    check("zero_a_ready", last_a_ready, 1'b1);
    #1;
    check("zero_pend0", bus.pend_mask[0], 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    check("zero_no_write", wr_seen - base, 0);

    // Asynchronous reset with three queued entries.
    for (int i = 0; i < 3; i++) step(1, 24, 32'h24, 1, 13 + i, 32'hD00 + i);
    bus.a_valid = 1'b1; bus.a_addr = 5'd24; bus.a_data = 32'h24; bus.b_valid = 1'b0;
    #7;
    reset = 1'b0;
    #1;
    check("mid_rst_rf_wr", bus.rf_wr, 1'b0);
    check("mid_rst_pend", bus.pend_mask, 0);
    check("mid_rst_a_ready", bus.a_ready, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    base = wr_seen;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
    check("mid_rst_no_write", wr_seen - base, 0);
    check("mid_rst_b_ready", last_b_ready, 1'b1);

    // Randomized traffic; sources hold requests that were not accepted.
    cav = 0; cbv = 0; caa = 0; cba = 0; cad = '0; cbd = '0;
    for (int n = 0; n < 3000; n++) begin
      pa = (n < 1000) ? 30 : (n < 2000) ? 70 : 95;
      if (!(cav && !last_a_ready)) begin
        cav = ($urandom_range(0, 99) < pa);
        caa = $urandom_range(0, 9);
        cad = $urandom;
      end
      if (!(cbv && !last_b_ready)) begin
        cbv = ($urandom_range(0, 99) < 45);
        cba = $urandom_range(0, 9);
        cbd = $urandom;
      end
      step(cav, caa, cad, cbv, cba, cbd);
      if (!cav || last_a_ready) cav = 0;
      if (!cbv || last_b_ready) cbv = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
